// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice is reused LSB-first across WIDTH clocks.
// A flip-flop carries between bits. Result and carry-out are registered with a one-cycle done pulse.

module fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_sum_s;
    logic             fa_carry_s;

    fa u_fa (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c     (cy_q),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    // Next-state logic: capture on accepted start, shift one bit per cycle in SHIFT
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        cy_d     = cy_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    cy_d    = cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sum_sr_d = WIDTH'({fa_sum_s, sum_sr_q} >> 1);
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cy_d     = fa_carry_s;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = sum_sr_d;
                    cout_d  = fa_carry_s;
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset aborts any addition in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= {WIDTH{1'b0}};
            b_sr_q   <= {WIDTH{1'b0}};
            sum_sr_q <= {WIDTH{1'b0}};
            cy_q     <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            sum_q    <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            cy_q     <= cy_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=16.

module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic [15:0] a16 = 16'd0, b16 = 16'd0;
    logic        cin8 = 1'b0, cin16 = 1'b0;
    logic        busy8, done8, cout8, busy16, done16, cout16;
    logic [7:0]  sum8;
    logic [15:0] sum16;
    int          checks = 0, failures = 0;
    int          dc8 = 0, dc16 = 0;
    logic [7:0]  prev_sum = 8'd0;
    logic        prev_cout = 1'b0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done8) dc8++;
        if (done16) dc16++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch one 8-bit addition and measure latency, busy length and held result
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input logic [7:0] psum, input logic pcout,
                         output int lat, output int bcnt, output logic stable);
        a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        lat = -1; bcnt = 0; stable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (busy8) begin
                bcnt++;
                if (sum8 !== psum || cout8 !== pcout) stable = 1'b0;
            end
            tick;
            if (done8) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b required 0/0/00/0", busy8, done8, sum8, cout8);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_zero;
        int lat, bcnt;
        logic stable;
        do_op(8'h00, 8'h00, 1'b0, prev_sum, prev_cout, lat, bcnt, stable);
        checks++;
        if (lat !== 8) begin failures++; $display("FAIL zero_latency: got %0d required 8", lat); end
        checks++;
        if (bcnt !== 8) begin failures++; $display("FAIL zero_busy_cycles: got %0d required 8", bcnt); end
        checks++;
        if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
            failures++; $display("FAIL zero_result: got %h/%b required 00/0", sum8, cout8);
        end
        tick;
        checks++;
        if (done8 !== 1'b0) begin failures++; $display("FAIL zero_done_width: done=%b required 0", done8); end
        prev_sum = 8'h00; prev_cout = 1'b0;
    endtask

    task automatic test_vectors;
        logic [7:0] va [3] = '{8'hFF, 8'hA5, 8'h3C};
        logic [7:0] vb [3] = '{8'h01, 8'h5A, 8'h47};
        logic       vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] es [3] = '{8'h00, 8'h00, 8'h83};
        logic       ec [3] = '{1'b1, 1'b1, 1'b0};
        int lat, bcnt;
        logic stable;
        for (int k = 0; k < 3; k++) begin
            do_op(va[k], vb[k], vc[k], prev_sum, prev_cout, lat, bcnt, stable);
            checks++;
            if (sum8 !== es[k] || cout8 !== ec[k]) begin
                failures++; $display("FAIL vector%0d_result: got %h/%b required %h/%b", k, sum8, cout8, es[k], ec[k]);
            end
            checks++;
            if (stable !== 1'b1) begin failures++; $display("FAIL vector%0d_hold: previous result changed while busy", k); end
            checks++;
            if (lat !== 8) begin failures++; $display("FAIL vector%0d_latency: got %0d required 8", k, lat); end
            prev_sum = es[k]; prev_cout = ec[k];
            tick;
        end
    endtask

    task automatic test_ignore_start;
        int lat, ndone;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1; end
            if (i == 4) start8 = 1'b0;
            tick;
            if (done8) begin lat = i; break; end
        end
        checks++;
        if (lat !== 8 || sum8 !== 8'h30 || cout8 !== 1'b0) begin
            failures++; $display("FAIL ignore_start: lat=%0d sum=%h cout=%b required 8/30/0", lat, sum8, cout8);
        end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin tick; if (done8) ndone++; end
        checks++;
        if (ndone !== 0) begin failures++; $display("FAIL ignore_start_extra_done: got %0d required 0", ndone); end
        prev_sum = 8'h30; prev_cout = 1'b0;
    endtask

    task automatic test_async_reset;
        int ndone, lat, bcnt;
        logic stable;
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        repeat (4) tick;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b required 0/0/00/0", busy8, done8, sum8, cout8);
        end
        #2;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin tick; if (done8) ndone++; end
        checks++;
        if (ndone !== 0) begin failures++; $display("FAIL async_reset_no_done: got %0d required 0", ndone); end
        do_op(8'h12, 8'h34, 1'b0, 8'h00, 1'b0, lat, bcnt, stable);
        checks++;
        if (lat !== 8 || sum8 !== 8'h46 || cout8 !== 1'b0) begin
            failures++; $display("FAIL after_reset_op: lat=%0d sum=%h cout=%b required 8/46/0", lat, sum8, cout8);
        end
        prev_sum = 8'h46; prev_cout = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        int d1, d2, nd;
        logic [7:0] s1, s2;
        logic c1, c2;
        d1 = -1; d2 = -1; nd = 0; s1 = 8'h00; s2 = 8'h00; c1 = 1'b0; c2 = 1'b0;
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick;
        a8 = 8'h80; b8 = 8'h80;
        for (int i = 1; i <= 25; i++) begin
            tick;
            if (i == 9) begin
                start8 = 1'b0;
                checks++;
                if (done8 !== 1'b0 || busy8 !== 1'b1) begin
                    failures++; $display("FAIL b2b_restart: done=%b busy=%b required 0/1", done8, busy8);
                end
            end
            if (done8) begin
                nd++;
                if (d1 < 0) begin d1 = i; s1 = sum8; c1 = cout8; end
                else if (d2 < 0) begin d2 = i; s2 = sum8; c2 = cout8; end
            end
        end
        checks++;
        if (nd !== 2 || d1 !== 8 || d2 - d1 !== 9) begin
            failures++; $display("FAIL b2b_spacing: pulses=%0d first=%0d second=%0d required 2/8/17", nd, d1, d2);
        end
        checks++;
        if (s1 !== 8'h02 || c1 !== 1'b0) begin failures++; $display("FAIL b2b_first: got %h/%b required 02/0", s1, c1); end
        checks++;
        if (s2 !== 8'h00 || c2 !== 1'b1) begin failures++; $display("FAIL b2b_second: got %h/%b required 00/1", s2, c2); end
        prev_sum = 8'h00; prev_cout = 1'b1;
    endtask

    task automatic test_random8;
        int lat, bcnt, d0, bad;
        logic stable;
        logic [7:0] ra, rb;
        logic rc;
        logic [8:0] exp9;
        d0 = dc8; bad = 0;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            do_op(ra, rb, rc, prev_sum, prev_cout, lat, bcnt, stable);
            checks++;
            if ({cout8, sum8} !== exp9 || lat !== 8 || stable !== 1'b1) begin
                failures++; bad++;
                if (bad < 5)
                    $display("FAIL rand8: %h+%h+%b got %b/%h lat=%0d required %b/%h lat=8", ra, rb, rc, cout8, sum8, lat, exp9[8], exp9[7:0]);
            end
            prev_sum = exp9[7:0]; prev_cout = exp9[8];
        end
        tick;
        tick;
        checks++;
        if (dc8 - d0 !== 1000) begin failures++; $display("FAIL rand8_done_count: got %0d required 1000", dc8 - d0); end
    endtask

    task automatic test_random16;
        int lat, d0, bad;
        logic [15:0] ra, rb;
        logic rc;
        logic [16:0] exp17;
        d0 = dc16; bad = 0;
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            exp17 = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            a16 = ra; b16 = rb; cin16 = rc; start16 = 1'b1;
            tick;
            start16 = 1'b0;
            lat = -1;
            for (int i = 1; i <= 30; i++) begin
                tick;
                if (done16) begin lat = i; break; end
            end
            checks++;
            if ({cout16, sum16} !== exp17 || lat !== 16) begin
                failures++; bad++;
                if (bad < 5)
                    $display("FAIL rand16: %h+%h+%b got %b/%h lat=%0d required %b/%h lat=16", ra, rb, rc, cout16, sum16, lat, exp17[16], exp17[15:0]);
            end
        end
        tick;
        tick;
        checks++;
        if (dc16 - d0 !== 1000) begin failures++; $display("FAIL rand16_done_count: got %0d required 1000", dc16 - d0); end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_vectors;
        test_ignore_start;
        test_async_reset;
        test_back_to_back;
        test_random8;
        test_random16;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
